// File: rtl/data_memory_unit.sv
// data_memory_unit: wait-stated word RAM serving the datapath's load/store port.
// Stalls the requester for 1+WAIT_STATES cycles per good access and for one
// cycle per faulting access (out of range, misaligned, or read+write together).
// Optional feature macro: DATA_MEMORY_BYTE_ENABLE_EN adds byte_en[3:0] lane
// masking on writes; byte_en==0 on a write faults.
module data_memory_unit #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h10010000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
`ifdef DATA_MEMORY_BYTE_ENABLE_EN
  input  logic [3:0]  byte_en,
`endif
  output logic [31:0] read_data,
  output logic        stall,
  output logic        fault
);

  localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned DATA_W   = 32;
  localparam logic [31:0] END_ADDR = BASE_ADDR + 32'(4 * DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  read_data_q, read_data_d;
  logic               fault_q, fault_d;

  logic [DATA_W-1:0]  ram [DEPTH_WORDS];

  logic               req_c;
  logic               in_range_c;
  logic               bad_c;
  logic [31:0]        offset_c;
  logic [IDX_W-1:0]   index_c;
  logic               ram_we_c;
  logic [DATA_W-1:0]  ram_wdata_c;

  // Request qualification and address decode; reset masks the request so
  // nothing is stalled or committed while reset_n is low.
  always_comb begin
    req_c      = (mem_read | mem_write) & reset_n;
    in_range_c = (address >= BASE_ADDR) && (address < END_ADDR);
    offset_c   = address - BASE_ADDR;
    index_c    = IDX_W'(offset_c >> 2);
    bad_c      = !in_range_c || (address[1:0] != 2'b00) || (mem_read && mem_write);
`ifdef DATA_MEMORY_BYTE_ENABLE_EN
    if (mem_write && (byte_en == 4'b0000)) begin
      bad_c = 1'b1;
    end
`endif
  end

  // Store data merge: full word, or per-lane merge with the current word.
  always_comb begin
`ifdef DATA_MEMORY_BYTE_ENABLE_EN
    ram_wdata_c = ram[index_c];
    for (int lane = 0; lane < 4; lane++) begin
      if (byte_en[lane]) begin
        ram_wdata_c[lane*8 +: 8] = write_data[lane*8 +: 8];
      end
    end
`else
    ram_wdata_c = write_data;
`endif
  end

  // Next-state, wait counter, load data and fault flag.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    read_data_d = read_data_q;
    fault_d     = fault_q;
    ram_we_c    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_c) begin
          if (bad_c) begin
            state_d     = S_DONE;
            fault_d     = 1'b1;
            read_data_d = '0;
          end else if (WAIT_STATES == 0) begin
            state_d = S_DONE;
            if (mem_write) begin
              ram_we_c = 1'b1;
            end else begin
              read_data_d = ram[index_c];
            end
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end

      S_WAIT: begin
        if (!req_c) begin
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = S_DONE;
          if (mem_write) begin
            ram_we_c = 1'b1;
          end else begin
            read_data_d = ram[index_c];
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        fault_d = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        fault_d = 1'b0;
      end
    endcase
  end

  // Control state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      read_data_q <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      read_data_q <= read_data_d;
      fault_q     <= fault_d;
    end
  end

  // RAM array; contents survive reset.
  always_ff @(posedge clock) begin
    if (ram_we_c) begin
      ram[index_c] <= ram_wdata_c;
    end
  end

  assign stall     = req_c & (state_q != S_DONE);
  assign read_data = read_data_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed bench for data_memory_unit: one instance with WAIT_STATES=2 and
// one with WAIT_STATES=0 sharing clock, reset, address and store data.
module tb_data_memory_unit;

  logic        clock;
  logic        reset_n;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        rd2, wr2, rd0, wr0;
  logic [31:0] read_data2, read_data0;
  logic        stall2, stall0, fault2, fault0;
`ifdef DATA_MEMORY_BYTE_ENABLE_EN
  logic [3:0]  byte_en;
`endif

  int n_vec = 0;
  int n_err = 0;

  data_memory_unit #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h10010000), .WAIT_STATES(2)) u_dut2 (
    .clock      (clock),
    .reset_n    (reset_n),
    .mem_read   (rd2),
    .mem_write  (wr2),
    .address    (address),
    .write_data (write_data),
`ifdef DATA_MEMORY_BYTE_ENABLE_EN
    .byte_en    (byte_en),
`endif
    .read_data  (read_data2),
    .stall      (stall2),
    .fault      (fault2)
  );

  data_memory_unit #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h10010000), .WAIT_STATES(0)) u_dut0 (
    .clock      (clock),
    .reset_n    (reset_n),
    .mem_read   (rd0),
    .mem_write  (wr0),
    .address    (address),
    .write_data (write_data),
`ifdef DATA_MEMORY_BYTE_ENABLE_EN
    .byte_en    (byte_en),
`endif
    .read_data  (read_data0),
    .stall      (stall0),
    .fault      (fault0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compare one observed value with its expected value.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic cur_stall(input bit sel);
    return sel ? stall0 : stall2;
  endfunction

  // One complete access: drive, count stall cycles, check DONE outputs, release.
  task automatic access(input bit sel, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int exp_stalls, input bit exp_fault,
                        input bit chk_rd, input logic [31:0] exp_rd,
                        input string tag);
    int n;
    @(negedge clock);
    address    = addr;
    write_data = wdata;
    if (sel) begin rd0 = rd; wr0 = wr; end
    else     begin rd2 = rd; wr2 = wr; end
    #1;
    n = 0;
    while (cur_stall(sel) && n < 40) begin
      @(posedge clock);
      #1;
      n++;
    end
    check_eq({tag, ".stalls"}, 32'(n), 32'(exp_stalls));
    check_eq({tag, ".fault"}, {31'b0, sel ? fault0 : fault2}, {31'b0, exp_fault});
    if (chk_rd) check_eq({tag, ".rdata"}, sel ? read_data0 : read_data2, exp_rd);
    @(negedge clock);
    rd2 = 1'b0; wr2 = 1'b0; rd0 = 1'b0; wr0 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n    = 1'b0;
    address    = 32'h0;
    write_data = 32'h0;
    rd2 = 1'b0; wr2 = 1'b0; rd0 = 1'b0; wr0 = 1'b0;
`ifdef DATA_MEMORY_BYTE_ENABLE_EN
    byte_en = 4'hF;
`endif
    #12;
    check_eq("rst.stall", {31'b0, stall2}, 32'd0);
    check_eq("rst.fault", {31'b0, fault2}, 32'd0);
    check_eq("rst.rdata2", read_data2, 32'h0);
    check_eq("rst.rdata0", read_data0, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    // WAIT_STATES=2: good accesses stall 3 cycles
    access(0, 0, 1, 32'h10010004, 32'hDEADBEEF, 3, 0, 0, 32'h0, "w2.wr4");
    access(0, 1, 0, 32'h10010004, 32'h0,        3, 0, 1, 32'hDEADBEEF, "w2.rd4");
    access(0, 0, 1, 32'h10010000, 32'h01020304, 3, 0, 0, 32'h0, "w2.wr0");

    // Faulting accesses stall one cycle and force read_data to 0
    access(0, 1, 0, 32'h10010002, 32'h0, 1, 1, 1, 32'h0, "w2.misal");
    access(0, 1, 0, 32'h10011000, 32'h0, 1, 1, 1, 32'h0, "w2.oor");
    access(0, 0, 1, 32'h1000FFFC, 32'hFFFFFFFF, 1, 1, 1, 32'h0, "w2.below");
    access(0, 1, 1, 32'h10010000, 32'hFFFFFFFF, 1, 1, 1, 32'h0, "w2.rdwr");
    access(0, 1, 0, 32'h10010000, 32'h0, 3, 0, 1, 32'h01020304, "w2.rd0");

    // Reset during WAIT of a write: abandoned, old data preserved
    access(0, 0, 1, 32'h10010008, 32'hCAFEF00D, 3, 0, 0, 32'h0, "w2.wr8");
    @(negedge clock);
    address = 32'h10010008; write_data = 32'h12345678; wr2 = 1'b1;
    @(posedge clock); #1;
    check_eq("rstw.pre_stall", {31'b0, stall2}, 32'd1);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_eq("rstw.stall", {31'b0, stall2}, 32'd0);
    check_eq("rstw.rdata", read_data2, 32'h0);
    @(negedge clock);
    wr2 = 1'b0;
    reset_n = 1'b1;
    access(0, 1, 0, 32'h10010008, 32'h0, 3, 0, 1, 32'hCAFEF00D, "rstw.rd8");

    // Abort by dropping mem_write during WAIT
    access(0, 0, 1, 32'h1001000C, 32'h0BADF00D, 3, 0, 0, 32'h0, "ab.wrC");
    access(0, 1, 0, 32'h1001000C, 32'h0, 3, 0, 1, 32'h0BADF00D, "ab.rdC");
    @(negedge clock);
    address = 32'h1001000C; write_data = 32'h55AA55AA; wr2 = 1'b1;
    @(posedge clock); #1;
    check_eq("ab.stall_wait", {31'b0, stall2}, 32'd1);
    @(negedge clock);
    wr2 = 1'b0;
    @(posedge clock); #1;
    check_eq("ab.stall_idle", {31'b0, stall2}, 32'd0);
    check_eq("ab.rdata_hold", read_data2, 32'h0BADF00D);
    access(0, 0, 1, 32'h10010010, 32'h77777777, 3, 0, 0, 32'h0, "ab.wr10");
    access(0, 1, 0, 32'h1001000C, 32'h0, 3, 0, 1, 32'h0BADF00D, "ab.rdC2");
    access(0, 1, 0, 32'h10010010, 32'h0, 3, 0, 1, 32'h77777777, "ab.rd10");

    // WAIT_STATES=0: every access stalls exactly one cycle
    access(1, 0, 1, 32'h10010000, 32'hA5A5A5A5, 1, 0, 0, 32'h0, "w0.wr0");
    access(1, 0, 1, 32'h10010FFC, 32'h5A5A5A5A, 1, 0, 0, 32'h0, "w0.wrlast");
    access(1, 1, 0, 32'h10010000, 32'h0, 1, 0, 1, 32'hA5A5A5A5, "w0.rd0");
    access(1, 1, 0, 32'h10010FFC, 32'h0, 1, 0, 1, 32'h5A5A5A5A, "w0.rdlast");
    access(1, 1, 0, 32'h10011000, 32'h0, 1, 1, 1, 32'h0, "w0.oor");
    access(1, 1, 0, 32'h10010FFC, 32'h0, 1, 0, 1, 32'h5A5A5A5A, "w0.rdlast2");

`ifdef DATA_MEMORY_BYTE_ENABLE_EN
    // Lane-masked writes
    byte_en = 4'hF;
    access(0, 0, 1, 32'h10010020, 32'h11223344, 3, 0, 0, 32'h0, "be.full");
    byte_en = 4'b0101;
    access(0, 0, 1, 32'h10010020, 32'hAABBCCDD, 3, 0, 0, 32'h0, "be.0101");
    byte_en = 4'b0000;
    access(0, 1, 0, 32'h10010020, 32'h0, 3, 0, 1, 32'h11BB33DD, "be.rd");
    access(0, 0, 1, 32'h10010020, 32'hFFFFFFFF, 1, 1, 1, 32'h0, "be.none");
    byte_en = 4'hF;
    access(0, 1, 0, 32'h10010020, 32'h0, 3, 0, 1, 32'h11BB33DD, "be.rd2");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
